// File: rtl/core_icache_controller.sv
// Instruction cache tag/valid controller: zero-latency hits, single-beat AXI refills,
// fetches that cross a block boundary, and fence.i flushes.
module core_icache_controller #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 52,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_core_req,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic                  i_flush,
  output logic                  o_core_stall,
  output logic                  o_core_valid,
  output logic                  o_core_err,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_offset,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  input  logic                  i_axi_rvalid,
  input  logic [1:0]            i_axi_rresp,
  output logic                  o_axi_rready
);

  localparam int Lines = 1 << INDEX_WIDTH;
  localparam int OffW  = 5;

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1} state_t;

  state_t                  r_state, w_state_next;
  logic [Lines-1:0]        r_valid;
  logic [TAG_WIDTH-1:0]    r_tag [Lines];
  logic                    r_flush_pend;

  logic [ADDR_WIDTH-1:0]   w_addr1;
  logic [INDEX_WIDTH-1:0]  w_idx0, w_idx1, w_fill_idx;
  logic [TAG_WIDTH-1:0]    w_tag0, w_tag1, w_fill_tag;
  logic                    w_straddle, w_hit0, w_hit1, w_hit;
  logic                    w_flush_now, w_clear, w_fill;
  logic                    w_unused;

  assign w_addr1    = i_addr_from_core + ADDR_WIDTH'(2);
  assign w_idx0     = i_addr_from_core[OffW +: INDEX_WIDTH];
  assign w_idx1     = w_addr1[OffW +: INDEX_WIDTH];
  assign w_tag0     = i_addr_from_core[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_tag1     = w_addr1[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_straddle = &i_addr_from_core[4:1];
  assign w_hit0     = r_valid[w_idx0] && (r_tag[w_idx0] == w_tag0);
  assign w_hit1     = r_valid[w_idx1] && (r_tag[w_idx1] == w_tag1);
  assign w_hit      = w_hit0 && (!w_straddle || w_hit1);
  assign w_flush_now = i_flush | r_flush_pend;
  assign w_unused   = ^{i_addr_from_core[0], w_addr1[OffW-1:0]};

  always_comb begin
    w_state_next    = r_state;
    w_clear         = 1'b0;
    w_fill          = 1'b0;
    w_fill_idx      = w_idx0;
    w_fill_tag      = w_tag0;
    o_core_stall    = 1'b0;
    o_core_valid    = 1'b0;
    o_core_err      = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_offset        = 1'b0;
    o_axi_arvalid   = 1'b0;
    o_axi_araddr    = '0;
    o_axi_rready    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_flush_now) begin
          o_core_stall = 1'b1;
          w_clear      = 1'b1;
        end else if (i_core_req) begin
          if (w_hit) begin
            o_rd_en      = 1'b1;
            o_core_valid = 1'b1;
          end else begin
            o_core_stall = 1'b1;
            w_state_next = w_hit0 ? StReq1 : StReq0;
          end
        end
      end
      StReq0, StReq1: begin
        o_core_stall  = 1'b1;
        o_axi_arvalid = 1'b1;
        o_axi_araddr  = (r_state == StReq0)
                      ? {i_addr_from_core[ADDR_WIDTH-1:OffW], {OffW{1'b0}}}
                      : {w_addr1[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
        if (i_axi_arready) w_state_next = (r_state == StReq0) ? StWait0 : StWait1;
      end
      StWait0, StWait1: begin
        o_core_stall = 1'b1;
        o_axi_rready = 1'b1;
        if (i_axi_rvalid) begin
          if (i_axi_rresp == 2'b00) begin
            o_wr_en         = 1'b1;
            o_block_replace = 1'b1;
            o_offset        = (r_state == StWait1);
            w_fill          = 1'b1;
            w_fill_idx      = (r_state == StWait1) ? w_idx1 : w_idx0;
            w_fill_tag      = (r_state == StWait1) ? w_tag1 : w_tag0;
            // A straddling fetch's second block lives in a different line, so its hit
            // status is unaffected by the fill of the first block.
            w_state_next    = (r_state == StWait0 && w_straddle && !w_hit1) ? StReq1 : StIdle;
          end else begin
            o_core_err   = 1'b1;
            o_core_stall = 1'b0;
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (i_rst) begin
      o_core_stall    = 1'b0;
      o_core_valid    = 1'b0;
      o_core_err      = 1'b0;
      o_rd_en         = 1'b0;
      o_wr_en         = 1'b0;
      o_block_replace = 1'b0;
      o_offset        = 1'b0;
      o_axi_arvalid   = 1'b0;
      o_axi_araddr    = '0;
      o_axi_rready    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_valid      <= '0;
        r_flush_pend <= 1'b0;
      end else begin
        if (w_fill) r_valid[w_fill_idx] <= 1'b1;
        if (i_flush) r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fill) r_tag[w_fill_idx] <= w_fill_tag;
  end

endmodule

// File: tb/tb_core_icache_controller.sv
// Directed bench for core_icache_controller: misses, hits, straddles, aliasing,
// refill errors, deferred flush and mid-refill reset.
module tb_core_icache_controller;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_core_req;
  logic [63:0] i_addr_from_core;
  logic        i_flush;
  logic        o_core_stall, o_core_valid, o_core_err;
  logic        o_rd_en, o_wr_en, o_block_replace, o_offset;
  logic        o_axi_arvalid, i_axi_arready, i_axi_rvalid, o_axi_rready;
  logic [63:0] o_axi_araddr;
  logic [1:0]  i_axi_rresp;

  int n_tests = 0;
  int n_fail  = 0;

  core_icache_controller dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_core_req       (i_core_req),
    .i_addr_from_core (i_addr_from_core),
    .i_flush          (i_flush),
    .o_core_stall     (o_core_stall),
    .o_core_valid     (o_core_valid),
    .o_core_err       (o_core_err),
    .o_rd_en          (o_rd_en),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_offset         (o_offset),
    .o_axi_arvalid    (o_axi_arvalid),
    .i_axi_arready    (i_axi_arready),
    .o_axi_araddr     (o_axi_araddr),
    .i_axi_rvalid     (i_axi_rvalid),
    .i_axi_rresp      (i_axi_rresp),
    .o_axi_rready     (o_axi_rready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Entered one tick after the edge that moves the FSM into a REQ state.
  task automatic do_refill(input logic [63:0] exp_ar, input logic exp_off,
                           input logic [1:0] resp, input logic fl);
    int n;
    n = 0;
    #1;
    while (!o_axi_arvalid && n < 8) begin
      step();
      #1;
      n++;
    end
    check("arvalid", 64'(o_axi_arvalid), 64'd1);
    check("araddr", o_axi_araddr, exp_ar);
    check("stall_req", 64'(o_core_stall), 64'd1);
    check("rd_en_req", 64'(o_rd_en), 64'd0);
    i_axi_arready = 1'b1;
    step();
    i_axi_arready = 1'b0;
    if (fl) begin
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
    end
    #1;
    check("rready", 64'(o_axi_rready), 64'd1);
    check("arvalid_wait", 64'(o_axi_arvalid), 64'd0);
    i_axi_rvalid = 1'b1;
    i_axi_rresp  = resp;
    #1;
    if (resp == 2'b00) begin
      check("wr_en", 64'(o_wr_en), 64'd1);
      check("block_replace", 64'(o_block_replace), 64'd1);
      check("offset", 64'(o_offset), 64'(exp_off));
      check("rd_en_wr", 64'(o_rd_en), 64'd0);
      check("err_ok", 64'(o_core_err), 64'd0);
    end else begin
      check("err", 64'(o_core_err), 64'd1);
      check("wr_en_err", 64'(o_wr_en), 64'd0);
      check("stall_err", 64'(o_core_stall), 64'd0);
    end
    step();
    i_axi_rvalid = 1'b0;
    i_axi_rresp  = 2'b00;
  endtask

  initial begin
    i_rst = 1'b1;
    i_core_req = 1'b0;
    i_addr_from_core = '0;
    i_flush = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b0;
    i_axi_rresp = 2'b00;
    #2;
    check("rst_outs", 64'({o_core_stall, o_core_valid, o_core_err, o_rd_en, o_wr_en,
                           o_block_replace, o_offset, o_axi_arvalid, o_axi_rready}), 64'd0);
    check("rst_araddr", o_axi_araddr, 64'd0);
    step();
    i_rst = 1'b0;
    #1;
    check("idle_stall", 64'(o_core_stall), 64'd0);
    check("idle_arvalid", 64'(o_axi_arvalid), 64'd0);

    // Cold miss at 0x1000
    i_core_req = 1'b1;
    i_addr_from_core = 64'h1000;
    #1;
    check("cold_stall", 64'(o_core_stall), 64'd1);
    check("cold_valid", 64'(o_core_valid), 64'd0);
    step();
    do_refill(64'h1000, 1'b0, 2'b00, 1'b0);
    #1;
    check("cold_hit_valid", 64'(o_core_valid), 64'd1);
    check("cold_hit_stall", 64'(o_core_stall), 64'd0);
    check("cold_hit_rd", 64'(o_rd_en), 64'd1);

    // Same-block refetch hits with no AR
    i_addr_from_core = 64'h1004;
    #1;
    check("refetch_valid", 64'(o_core_valid), 64'd1);
    step();
    check("refetch_no_ar", 64'(o_axi_arvalid), 64'd0);
    check("refetch_stall", 64'(o_core_stall), 64'd0);

    // Aliasing 0x2000 evicts 0x1000
    i_addr_from_core = 64'h2000;
    #1;
    check("alias_stall", 64'(o_core_stall), 64'd1);
    step();
    do_refill(64'h2000, 1'b0, 2'b00, 1'b0);
    #1;
    check("alias_hit", 64'(o_core_valid), 64'd1);
    i_addr_from_core = 64'h1000;
    #1;
    check("alias_back_miss", 64'(o_core_stall), 64'd1);
    check("alias_back_valid", 64'(o_core_valid), 64'd0);
    step();
    do_refill(64'h1000, 1'b0, 2'b00, 1'b0);

    // Straddle with both lines cold for tag 5
    i_addr_from_core = 64'h501E;
    #1;
    check("strad_stall", 64'(o_core_stall), 64'd1);
    step();
    do_refill(64'h5000, 1'b0, 2'b00, 1'b0);
    do_refill(64'h5020, 1'b1, 2'b00, 1'b0);
    #1;
    check("strad_hit", 64'(o_core_valid), 64'd1);
    check("strad_stall_off", 64'(o_core_stall), 64'd0);

    // Refill error on 0x3000
    i_addr_from_core = 64'h3000;
    #1;
    step();
    do_refill(64'h3000, 1'b0, 2'b10, 1'b0);
    #1;
    check("err_pulse_gone", 64'(o_core_err), 64'd0);
    check("err_retry_miss", 64'(o_core_stall), 64'd1);
    check("err_retry_valid", 64'(o_core_valid), 64'd0);

    // Retry with flush in WAIT0: fill completes, then flush invalidates
    step();
    do_refill(64'h3000, 1'b0, 2'b00, 1'b1);
    #1;
    check("flush_apply_stall", 64'(o_core_stall), 64'd1);
    check("flush_apply_valid", 64'(o_core_valid), 64'd0);
    check("flush_apply_ar", 64'(o_axi_arvalid), 64'd0);
    step();
    check("post_flush_miss", 64'(o_core_stall), 64'd1);
    check("post_flush_valid", 64'(o_core_valid), 64'd0);
    step();
    check("req0_arvalid", 64'(o_axi_arvalid), 64'd1);
    check("req0_araddr", o_axi_araddr, 64'h3000);

    // Reset during REQ0
    i_rst = 1'b1;
    #1;
    check("midrst_outs", 64'({o_core_stall, o_core_valid, o_core_err, o_rd_en, o_wr_en,
                              o_block_replace, o_offset, o_axi_arvalid, o_axi_rready}), 64'd0);
    check("midrst_araddr", o_axi_araddr, 64'd0);
    step();
    i_rst = 1'b0;
    #1;
    check("after_rst_miss", 64'(o_core_stall), 64'd1);
    check("after_rst_valid", 64'(o_core_valid), 64'd0);
    i_core_req = 1'b0;
    #1;
    check("noreq_stall", 64'(o_core_stall), 64'd0);
    check("noreq_ar", 64'(o_axi_arvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
